alu_test_sequencer: RTL

Sequencer for the ALU experiment. It drives the 3-bit operand-select code into the operand ROM, which produces A/B. It also drives the 3-bit ALU operation code, waits a programmable settle time, and captures the ALU result and flags. It sweeps all 8 operand pairs × 8 operations, or advances one item per step pulse. It sits between the board switches/buttons and the operand ROM + ALU. It keeps a running signature so a whole sweep can be checked with one 32-bit compare.

---
 rtl/alu_test_sequencer_pkg.sv | 34 +++
 rtl/alu_test_sequencer_settle_counter.sv | 29 ++
 rtl/alu_test_sequencer.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/alu_test_sequencer_pkg.sv
// Shared definitions for the ALU test sequencer.
// Contents: FSM state encoding, ALU op codes, signature seed, sweep length.
// Imported by alu_test_sequencer and settle_counter.
package alu_test_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_APPLY   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_PAUSE   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    OP_AND = 3'd0,
    OP_OR  = 3'd1,
    OP_XOR = 3'd2,
    OP_NOR = 3'd3,
    OP_ADD = 3'd4,
    OP_SUB = 3'd5,
    OP_SLT = 3'd6,
    OP_SLL = 3'd7
  } alu_op_t;

  localparam logic [31:0] SIG_INIT   = 32'h0000_0000;
  localparam int          ITEM_COUNT = 64;
  localparam logic [5:0]  LAST_ITEM  = 6'(ITEM_COUNT - 1);

  // One signature step: rotate left by one, then fold in the new result.
  function automatic logic [31:0] sig_fold(input logic [31:0] sig, input logic [31:0] f);
    return {sig[30:0], sig[31]} ^ f;
  endfunction

endpackage

// File: rtl/alu_test_sequencer_settle_counter.sv
// Settle-time counter: 4-bit down-counter with synchronous load and zero flag.
// Ports: clk, rst (sync, active-high), load/load_val, dec (decrement enable),
//        zero (count == 0). Load has priority over decrement.
module settle_counter
  import alu_test_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  assign zero = (cnt == 4'd0);

endmodule

// File: rtl/alu_test_sequencer.sv
// ALU experiment sequencer: walks 8 operand pairs x 8 ALU ops, holds each item
// SETTLE cycles, captures F/ZF/OF and folds F into a 32-bit signature.
// Ports: clk, rst, start/step_mode/step (controls), F/ZF/OF (from ALU),
//        AB_SW/ALU_OP (to ROM/ALU), F_cap/ZF_cap/OF_cap, signature, item, busy, done.
module alu_test_sequencer
  import alu_test_sequencer_pkg::*;
#(
  parameter int unsigned SETTLE = 2  // legal 1..15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        step_mode,
  input  logic        step,
  input  logic [31:0] F,
  input  logic        ZF,
  input  logic        OF,
  output logic [2:0]  AB_SW,
  output logic [2:0]  ALU_OP,
  output logic [31:0] F_cap,
  output logic        ZF_cap,
  output logic        OF_cap,
  output logic [31:0] signature,
  output logic [5:0]  item,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t     state, state_nxt;
  logic       step_lat;
  logic       done_q;
  logic       cnt_zero;
  logic       cnt_load, cnt_dec;
  logic       start_sweep, do_capture, advance;
  logic [5:0] item_inc;

  assign item_inc = item + 6'd1;

  settle_counter u_settle (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (SETTLE_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_nxt   = state;
    start_sweep = 1'b0;
    do_capture  = 1'b0;
    advance     = 1'b0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          start_sweep = 1'b1;
          cnt_load    = 1'b1;
          state_nxt   = ST_APPLY;
        end
      end
      ST_APPLY: begin
        // Counter was loaded with SETTLE-1 on entry, so APPLY lasts SETTLE cycles.
        if (cnt_zero) begin
          state_nxt = ST_CAPTURE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_CAPTURE: begin
        do_capture = 1'b1;
        if (item == LAST_ITEM) begin
          state_nxt = ST_DONE;
        end else if (step_lat) begin
          state_nxt = ST_PAUSE;
        end else begin
          advance   = 1'b1;
          cnt_load  = 1'b1;
          state_nxt = ST_APPLY;
        end
      end
      ST_PAUSE: begin
        if (step) begin
          advance   = 1'b1;
          cnt_load  = 1'b1;
          state_nxt = ST_APPLY;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      step_lat  <= 1'b0;
      item      <= 6'd0;
      AB_SW     <= 3'd0;
      ALU_OP    <= 3'd0;
      F_cap     <= 32'd0;
      ZF_cap    <= 1'b0;
      OF_cap    <= 1'b0;
      signature <= SIG_INIT;
      done_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_sweep) begin
        step_lat  <= step_mode;
        item      <= 6'd0;
        AB_SW     <= 3'd0;
        ALU_OP    <= 3'd0;
        F_cap     <= 32'd0;
        ZF_cap    <= 1'b0;
        OF_cap    <= 1'b0;
        signature <= SIG_INIT;
      end
      if (do_capture) begin
        F_cap     <= F;
        ZF_cap    <= ZF;
        OF_cap    <= OF;
        signature <= sig_fold(signature, F);
      end
      // Operand select follows the item index on the edge that enters APPLY;
      // after item 63 nothing advances, so the selects hold 3'b111 in DONE.
      if (advance) begin
        item   <= item_inc;
        AB_SW  <= item_inc[2:0];
        ALU_OP <= item_inc[5:3];
      end
      // done trails entry to DONE by one cycle and drops on the restarting edge.
      done_q <= (state == ST_DONE) && !start;
    end
  end

  assign busy = (state == ST_APPLY) || (state == ST_CAPTURE) || (state == ST_PAUSE);
  assign done = done_q;

endmodule
